// File: rtl/tamagotchi_pkg.sv
// Shared types and timing defaults for the tamagotchi button front-end.
package tamagotchi_pkg;

  // Button conditioner FSM states.
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPressDeb = 3'd1,
    StPressed  = 3'd2,
    StLongHeld = 3'd3,
    StRelDeb   = 3'd4
  } btn_state_e;

  // Default timing at a 50 MHz system clock.
  localparam int unsigned DEB_20MS_50MHZ = 1_000_000;
  localparam int unsigned LONG_5S_50MHZ  = 250_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pad inputs, with a configurable reset value.
module sync_2ff #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the pad value through two flops to settle metastability.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchroniser, debounce FSM and short/long press classifier.
module btn_conditioner
  import tamagotchi_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEB_20MS_50MHZ,
  parameter int unsigned LONG_CYCLES     = LONG_5S_50MHZ,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic long_pulse,
  output logic holding
);

  localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HoldW = $clog2(LONG_CYCLES);

  // The edge entering a debounce state is already the first stable sample, so the
  // D-th stable sample is seen with the counter at D-2.
  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 2);
  localparam logic [DebW-1:0]  DebMax   = DebW'(DEBOUNCE_CYCLES - 1);
  // Hold counter starts at 0 on acceptance; the L-th held sample sees L-1.
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);

  logic       raw_sync;
  logic       btn_sync;

  btn_state_e       state_q, state_d;
  logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             long_fired_q, long_fired_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             long_q, long_d;
  logic             holding_q, holding_d;

  logic [DebW-1:0]  deb_inc;
  logic [HoldW-1:0] hold_inc;

  // Synchroniser resets to the electrical "released" level of the pad.
  sync_2ff #(
    .ResetVal (BTN_ACTIVE_LOW)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (btn_raw),
    .q_o    (raw_sync)
  );

  // Normalise polarity so that 1 always means pressed.
  assign btn_sync = raw_sync ^ BTN_ACTIVE_LOW;

  // Saturating increments; the counters never wrap.
  always_comb begin
    deb_inc  = (deb_cnt_q == DebMax) ? deb_cnt_q : deb_cnt_q + DebW'(1);
    hold_inc = (hold_cnt_q == HoldLast) ? hold_cnt_q : hold_cnt_q + HoldW'(1);
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_d      = state_q;
    deb_cnt_d    = deb_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    long_fired_d = long_fired_q;
    level_d      = level_q;
    press_d      = 1'b0;
    long_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (btn_sync) begin
          state_d   = StPressDeb;
          deb_cnt_d = '0;
        end
      end

      StPressDeb: begin
        if (!btn_sync) begin
          // Bounce: drop back, partial count is discarded on next entry.
          state_d = StIdle;
        end else if (deb_cnt_q == DebLast) begin
          state_d    = StPressed;
          level_d    = 1'b1;
          hold_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_inc;
        end
      end

      StPressed: begin
        if (!btn_sync) begin
          state_d   = StRelDeb;
          deb_cnt_d = '0;
        end else if (hold_cnt_q == HoldLast) begin
          state_d = StLongHeld;
          long_d  = 1'b1;
        end else begin
          hold_cnt_d = hold_inc;
        end
      end

      StLongHeld: begin
        if (!btn_sync) begin
          state_d      = StRelDeb;
          deb_cnt_d    = '0;
          long_fired_d = 1'b1;
        end
      end

      StRelDeb: begin
        // hold_cnt is left untouched here so a release glitch resumes the hold.
        if (btn_sync) begin
          state_d = long_fired_q ? StLongHeld : StPressed;
        end else if (deb_cnt_q == DebLast) begin
          state_d      = StIdle;
          level_d      = 1'b0;
          press_d      = ~long_fired_q;
          long_fired_d = 1'b0;
        end else begin
          deb_cnt_d = deb_inc;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    holding_d = (state_d == StLongHeld) || ((state_d == StRelDeb) && long_fired_d);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      deb_cnt_q    <= '0;
      hold_cnt_q   <= '0;
      long_fired_q <= 1'b0;
      level_q      <= 1'b0;
      press_q      <= 1'b0;
      long_q       <= 1'b0;
      holding_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      deb_cnt_q    <= deb_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      long_fired_q <= long_fired_d;
      level_q      <= level_d;
      press_q      <= press_d;
      long_q       <= long_d;
      holding_q    <= holding_d;
    end
  end

  assign btn_level   = level_q;
  assign press_pulse = press_q;
  assign long_pulse  = long_q;
  assign holding     = holding_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=20, active-low button.
module tb_btn_conditioner;

  logic clk     = 1'b0;
  logic reset   = 1'b0;
  logic btn_raw = 1'b1;
  logic btn_level;
  logic press_pulse;
  logic long_pulse;
  logic holding;

  int n_checks = 0;
  int n_fail   = 0;

  // Running event counts, written only by the monitor below.
  int   press_cnt    = 0;
  int   long_cnt     = 0;
  int   level_hi_cnt = 0;
  int   width_viol   = 0;
  int   overlap_viol = 0;
  logic press_prev   = 1'b0;
  logic long_prev    = 1'b0;

  int pb, lb, hb;

  btn_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (20),
    .BTN_ACTIVE_LOW  (1'b1)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .press_pulse (press_pulse),
    .long_pulse  (long_pulse),
    .holding     (holding)
  );

  always #5 clk = ~clk;

  // Pulse bookkeeping, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      if (press_pulse) press_cnt++;
      if (long_pulse) long_cnt++;
      if (btn_level) level_hi_cnt++;
      if ((press_pulse && press_prev) || (long_pulse && long_prev)) width_viol++;
      if (press_pulse && long_pulse) overlap_viol++;
    end
    press_prev = press_pulse;
    long_prev  = long_pulse;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clocks; inputs are driven and outputs sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    tick(2);
    check_eq("rst_level", btn_level, 0);
    check_eq("rst_press", press_pulse, 0);
    check_eq("rst_long", long_pulse, 0);
    check_eq("rst_holding", holding, 0);
    reset = 1'b1;
    tick(3);
    check_eq("idle_level", btn_level, 0);

    // 1. Clean short press
    pb = press_cnt; lb = long_cnt;
    btn_raw = 1'b0;
    tick(5);
    check_eq("t1_level_early", btn_level, 0);
    tick(1);
    check_eq("t1_level_rise", btn_level, 1);
    tick(4);
    btn_raw = 1'b1;
    tick(5);
    check_eq("t1_level_hold", btn_level, 1);
    check_eq("t1_press_early", press_pulse, 0);
    tick(1);
    check_eq("t1_level_fall", btn_level, 0);
    check_eq("t1_press_pulse", press_pulse, 1);
    tick(4);
    check_eq("t1_press_count", press_cnt - pb, 1);
    check_eq("t1_long_count", long_cnt - lb, 0);

    // 2. Bounce: never qualifies
    pb = press_cnt; lb = long_cnt; hb = level_hi_cnt;
    for (int i = 0; i < 5; i++) begin
      btn_raw = 1'b0;
      tick(2);
      btn_raw = 1'b1;
      tick(2);
    end
    tick(10);
    check_eq("t2_level_never", level_hi_cnt - hb, 0);
    check_eq("t2_press_count", press_cnt - pb, 0);
    check_eq("t2_long_count", long_cnt - lb, 0);

    // 3. Long press
    pb = press_cnt; lb = long_cnt;
    btn_raw = 1'b0;
    tick(6);
    check_eq("t3_level_rise", btn_level, 1);
    tick(19);
    check_eq("t3_long_early", long_pulse, 0);
    check_eq("t3_holding_early", holding, 0);
    tick(1);
    check_eq("t3_long_pulse", long_pulse, 1);
    check_eq("t3_holding_on", holding, 1);
    tick(1);
    check_eq("t3_long_width", long_pulse, 0);
    check_eq("t3_holding_kept", holding, 1);
    tick(13);
    btn_raw = 1'b1;
    tick(5);
    check_eq("t3_holding_reldeb", holding, 1);
    check_eq("t3_level_reldeb", btn_level, 1);
    tick(1);
    check_eq("t3_level_fall", btn_level, 0);
    check_eq("t3_holding_off", holding, 0);
    check_eq("t3_no_press", press_pulse, 0);
    tick(5);
    check_eq("t3_long_count", long_cnt - lb, 1);
    check_eq("t3_press_count", press_cnt - pb, 0);

    // 4. Release glitch while pressed; hold count resumes from frozen value
    pb = press_cnt; lb = long_cnt;
    btn_raw = 1'b0;
    tick(6);
    check_eq("t4_level_rise", btn_level, 1);
    tick(4);
    btn_raw = 1'b1;
    tick(2);
    btn_raw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check_eq("t4_level_glitch", btn_level, 1);
    end
    tick(12);
    check_eq("t4_long_early", long_pulse, 0);
    tick(1);
    check_eq("t4_long_pulse", long_pulse, 1);
    check_eq("t4_press_none", press_cnt - pb, 0);
    tick(1);
    btn_raw = 1'b1;
    tick(12);
    check_eq("t4_long_count", long_cnt - lb, 1);
    check_eq("t4_press_count", press_cnt - pb, 0);
    check_eq("t4_level_end", btn_level, 0);

    // 5. Reset mid-hold, button kept pressed
    pb = press_cnt; lb = long_cnt;
    btn_raw = 1'b0;
    tick(6);
    check_eq("t5_level_rise", btn_level, 1);
    tick(10);
    reset = 1'b0;
    #1;
    check_eq("t5_rst_level", btn_level, 0);
    check_eq("t5_rst_press", press_pulse, 0);
    check_eq("t5_rst_long", long_pulse, 0);
    check_eq("t5_rst_holding", holding, 0);
    tick(3);
    check_eq("t5_rst_level_held", btn_level, 0);
    reset = 1'b1;
    tick(5);
    check_eq("t5_requal_early", btn_level, 0);
    tick(1);
    check_eq("t5_requal_rise", btn_level, 1);
    tick(19);
    check_eq("t5_long_early", long_pulse, 0);
    tick(1);
    check_eq("t5_long_pulse", long_pulse, 1);
    btn_raw = 1'b1;
    tick(12);
    check_eq("t5_press_count", press_cnt - pb, 0);
    check_eq("t5_long_count", long_cnt - lb, 1);

    // 6. Back-to-back short presses
    pb = press_cnt;
    for (int p = 0; p < 2; p++) begin
      btn_raw = 1'b0;
      tick(8);
      btn_raw = 1'b1;
      tick(5);
      check_eq("t6_press_early", press_pulse, 0);
      tick(1);
      check_eq("t6_press_pulse", press_pulse, 1);
      tick(1);
      check_eq("t6_press_width", press_pulse, 0);
      tick(5);
    end
    check_eq("t6_press_count", press_cnt - pb, 2);
    check_eq("pulse_width_viol", width_viol, 0);
    check_eq("pulse_overlap_viol", overlap_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
